// File: rtl/io_cycle_ctrl.sv
// io_cycle_ctrl
//
// Sequences one CPU IO bus cycle:
//   1. Accept a microcode IO request.
//   2. Request the bus and wait for the grant.
//   3. Hold iolatch while waiting for the device acknowledge.
//   4. Strobe io_done for one enabled cycle.
// If no acknowledge arrives within TIMEOUT enabled WAIT cycles, the cycle
// is still completed, and the sticky non-existent-device flag (nxd) is set.
//
// Parameters
//   TIMEOUT    enabled WAIT cycles allowed before NXD (1..2**CNT_WIDTH)
//   CNT_WIDTH  width of the timeout down-counter
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   clken        clock enable; nothing changes on edges with clken=0
//   io_start     request a cycle (sampled in IDLE only)
//   io_write     direction of the request (1 = write), captured with io_start
//   bus_grant    arbiter grant (sampled in REQ)
//   bus_ack      device acknowledge (sampled in WAIT)
//   nxd_clr      clears the sticky nxd flag
//   bus_req      high in REQ
//   bus_wr       captured direction, valid while bus_req or iolatch is high
//   iolatch      high in WAIT
//   io_busy      high in any state but IDLE
//   io_done      high in DONE
//   nxd          sticky non-existent-device flag
//   dbg_state    current FSM state (0 IDLE, 1 REQ, 2 WAIT, 3 DONE)
//
// Handshake: io_start is a level sampled only on enabled edges in IDLE.
// Requests made outside IDLE are dropped, not queued. bus_grant and bus_ack
// are likewise levels, sampled only in REQ and WAIT respectively.
module io_cycle_ctrl #(
  parameter int TIMEOUT   = 64,
  parameter int CNT_WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clken,
  input  logic       io_start,
  input  logic       io_write,
  input  logic       bus_grant,
  input  logic       bus_ack,
  input  logic       nxd_clr,
  output logic       bus_req,
  output logic       bus_wr,
  output logic       iolatch,
  output logic       io_busy,
  output logic       io_done,
  output logic       nxd,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // WAIT runs from TIMEOUT-1 down to 0 inclusive, i.e. exactly TIMEOUT edges.
  localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(TIMEOUT - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;
  logic                 r_bus_wr;
  logic                 w_bus_wr_nxt;
  logic                 r_nxd;
  logic                 w_nxd_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_bus_wr <= 1'b0;
      r_nxd    <= 1'b0;
    end else if (clken) begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_bus_wr <= w_bus_wr_nxt;
      r_nxd    <= w_nxd_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_bus_wr_nxt = r_bus_wr;
    // A timeout assignment below overrides the clear, so set beats clear.
    w_nxd_nxt    = r_nxd & ~nxd_clr;
    case (r_state)
      S_IDLE: begin
        if (io_start) begin
          w_bus_wr_nxt = io_write;
          w_state_nxt  = S_REQ;
        end
      end
      S_REQ: begin
        if (bus_grant) begin
          w_cnt_nxt   = CNT_LOAD;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // Acknowledge takes priority over an expiring counter.
        if (bus_ack) begin
          w_state_nxt = S_DONE;
        end else if (r_cnt == '0) begin
          w_nxd_nxt   = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_WIDTH'(1);
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus_req   = (r_state == S_REQ);
  assign iolatch   = (r_state == S_WAIT);
  assign io_busy   = (r_state != S_IDLE);
  assign io_done   = (r_state == S_DONE);
  assign bus_wr    = r_bus_wr;
  assign nxd       = r_nxd;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_io_cycle_ctrl.sv
// Testbench for io_cycle_ctrl.
// u_dut4 (TIMEOUT=4) carries the main vector table and the reset-mid-WAIT
// sequence. u_dut3 (TIMEOUT=3, CNT_WIDTH=2) carries the clock-enable
// stall sequence. Both instances share the same inputs.
// Observed output word: {bus_req, bus_wr, iolatch, io_busy, io_done, nxd}.
module tb_io_cycle_ctrl;

  logic clk;
  logic rst_n;
  logic clken;
  logic io_start;
  logic io_write;
  logic bus_grant;
  logic bus_ack;
  logic nxd_clr;

  logic       req4, wr4, latch4, busy4, done4, nxd4;
  logic [1:0] st4;
  logic       req3, wr3, latch3, busy3, done3, nxd3;
  logic [1:0] st3;

  logic [5:0] obs4;
  logic [5:0] obs3;
  assign obs4 = {req4, wr4, latch4, busy4, done4, nxd4};
  assign obs3 = {req3, wr3, latch3, busy3, done3, nxd3};

  io_cycle_ctrl #(.TIMEOUT(4), .CNT_WIDTH(8)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .clken(clken), .io_start(io_start),
    .io_write(io_write), .bus_grant(bus_grant), .bus_ack(bus_ack),
    .nxd_clr(nxd_clr), .bus_req(req4), .bus_wr(wr4), .iolatch(latch4),
    .io_busy(busy4), .io_done(done4), .nxd(nxd4), .dbg_state(st4)
  );

  io_cycle_ctrl #(.TIMEOUT(3), .CNT_WIDTH(2)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .clken(clken), .io_start(io_start),
    .io_write(io_write), .bus_grant(bus_grant), .bus_ack(bus_ack),
    .nxd_clr(nxd_clr), .bus_req(req3), .bus_wr(wr3), .iolatch(latch3),
    .io_busy(busy3), .io_done(done3), .nxd(nxd3), .dbg_state(st3)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- vectors / scoreboard ----------------
  typedef struct {
    string      name;
    logic       en;
    logic       start;
    logic       wr;
    logic       grant;
    logic       ack;
    logic       clr;
    logic [5:0] exp;
    logic [5:0] mask;
  } vec_t;

  localparam logic [5:0] M_ALL  = 6'b111111;
  localparam logic [5:0] M_NOWR = 6'b101111; // bus_wr is only meaningful in REQ/WAIT

  vec_t       vecs_a[$];
  vec_t       vecs_b[$];
  logic [5:0] exp_q[$];
  logic [5:0] mask_q[$];
  int         total = 0;
  int         bad   = 0;

  task automatic add_v(input int sel, input string n, input logic en,
                       input logic st, input logic wr, input logic gr,
                       input logic ack, input logic clr,
                       input logic [5:0] e, input logic [5:0] m);
    vec_t v;
    v.name = n; v.en = en; v.start = st; v.wr = wr; v.grant = gr;
    v.ack = ack; v.clr = clr; v.exp = e; v.mask = m;
    if (sel == 0) vecs_a.push_back(v);
    else          vecs_b.push_back(v);
  endtask

  task automatic check(input string name, input logic [5:0] got,
                       input logic [5:0] exp, input logic [5:0] mask);
    total++;
    if (((got ^ exp) & mask) !== 6'b0) begin
      bad++;
      $display("FAIL %s: got=%b want=%b (mask %b)", name, got, exp, mask);
    end
  endtask

  task automatic check_st(input string name, input logic [1:0] got,
                          input logic [1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: state got=%0d want=%0d", name, got, exp);
    end
  endtask

  task automatic drive_idle();
    clken = 1'b1; io_start = 1'b0; io_write = 1'b0;
    bus_grant = 1'b0; bus_ack = 1'b0; nxd_clr = 1'b0;
  endtask

  // Drive one record for one clock. Its expected output goes into the
  // scoreboard and is popped and compared #1 after the edge.
  task automatic apply(input vec_t v, input int sel);
    logic [5:0] e;
    logic [5:0] m;
    clken = v.en; io_start = v.start; io_write = v.wr;
    bus_grant = v.grant; bus_ack = v.ack; nxd_clr = v.clr;
    exp_q.push_back(v.exp);
    mask_q.push_back(v.mask);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    m = mask_q.pop_front();
    check(v.name, (sel == 0) ? obs4 : obs3, e, m);
  endtask

  task automatic pulse_reset();
    drive_idle();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Table A, u_dut4 (TIMEOUT=4).
    //     name                   en st wr gr ak cl  expected    mask
    // Normal write cycle, ack on the 2nd WAIT edge.
    add_v(0, "t2_start",       1, 1, 1, 0, 0, 0, 6'b110100, M_ALL);
    add_v(0, "t2_grant",       1, 0, 0, 1, 0, 0, 6'b011100, M_ALL);
    add_v(0, "t2_wait1",       1, 0, 0, 0, 0, 0, 6'b011100, M_ALL);
    add_v(0, "t2_ack",         1, 0, 0, 0, 1, 0, 6'b000110, M_NOWR);
    add_v(0, "t2_idle",        1, 0, 0, 0, 0, 0, 6'b000000, M_NOWR);
    // Read cycle that times out: iolatch high for 4 cycles.
    add_v(0, "t3_start",       1, 1, 0, 0, 0, 0, 6'b100100, M_ALL);
    add_v(0, "t3_grant",       1, 0, 0, 1, 0, 0, 6'b001100, M_ALL);
    add_v(0, "t3_wait1",       1, 0, 0, 0, 0, 0, 6'b001100, M_ALL);
    add_v(0, "t3_wait2",       1, 0, 0, 0, 0, 0, 6'b001100, M_ALL);
    add_v(0, "t3_wait3",       1, 0, 0, 0, 0, 0, 6'b001100, M_ALL);
    add_v(0, "t3_timeout",     1, 0, 0, 0, 0, 0, 6'b000111, M_NOWR);
    add_v(0, "t3_idle_nxd",    1, 0, 0, 0, 0, 0, 6'b000001, M_NOWR);
    // A successful write cycle leaves the sticky nxd set.
    add_v(0, "t3_ok_start",    1, 1, 1, 0, 0, 0, 6'b110101, M_ALL);
    add_v(0, "t3_ok_grant",    1, 0, 0, 1, 0, 0, 6'b011101, M_ALL);
    add_v(0, "t3_ok_ack",      1, 0, 0, 0, 1, 0, 6'b000111, M_NOWR);
    add_v(0, "t3_ok_idle",     1, 0, 0, 0, 0, 0, 6'b000001, M_NOWR);
    add_v(0, "t3_clr",         1, 0, 0, 0, 0, 1, 6'b000000, M_NOWR);
    // Ack coincides with counter==0 on the 4th WAIT edge: ack wins.
    add_v(0, "t4_start",       1, 1, 0, 0, 0, 0, 6'b100100, M_ALL);
    add_v(0, "t4_grant",       1, 0, 0, 1, 0, 0, 6'b001100, M_ALL);
    add_v(0, "t4_wait1",       1, 0, 0, 0, 0, 0, 6'b001100, M_ALL);
    add_v(0, "t4_wait2",       1, 0, 0, 0, 0, 0, 6'b001100, M_ALL);
    add_v(0, "t4_wait3",       1, 0, 0, 0, 0, 0, 6'b001100, M_ALL);
    add_v(0, "t4_ack_last",    1, 0, 0, 0, 1, 0, 6'b000110, M_NOWR);
    add_v(0, "t4_idle",        1, 0, 0, 0, 0, 0, 6'b000000, M_NOWR);
    // Ack without grant stays in REQ; io_start in REQ/WAIT/DONE is dropped.
    add_v(0, "t6_start",       1, 1, 1, 0, 0, 0, 6'b110100, M_ALL);
    add_v(0, "t6_ack_in_req",  1, 0, 0, 0, 1, 0, 6'b110100, M_ALL);
    add_v(0, "t6_start_req",   1, 1, 0, 0, 1, 0, 6'b110100, M_ALL);
    add_v(0, "t6_grant",       1, 0, 0, 1, 0, 0, 6'b011100, M_ALL);
    add_v(0, "t6_start_wait",  1, 1, 0, 0, 0, 0, 6'b011100, M_ALL);
    add_v(0, "t6_ack",         1, 0, 0, 0, 1, 0, 6'b000110, M_NOWR);
    add_v(0, "t6_start_done",  1, 1, 0, 0, 0, 0, 6'b000000, M_NOWR);
    add_v(0, "t6_no_second",   1, 0, 0, 0, 0, 0, 6'b000000, M_NOWR);
    // nxd_clr on the timeout edge: set wins.
    add_v(0, "t6c_start",      1, 1, 0, 0, 0, 0, 6'b100100, M_ALL);
    add_v(0, "t6c_grant",      1, 0, 0, 1, 0, 0, 6'b001100, M_ALL);
    add_v(0, "t6c_wait1",      1, 0, 0, 0, 0, 0, 6'b001100, M_ALL);
    add_v(0, "t6c_wait2",      1, 0, 0, 0, 0, 0, 6'b001100, M_ALL);
    add_v(0, "t6c_wait3",      1, 0, 0, 0, 0, 0, 6'b001100, M_ALL);
    add_v(0, "t6c_to_and_clr", 1, 0, 0, 0, 0, 1, 6'b000111, M_NOWR);
    add_v(0, "t6c_idle",       1, 0, 0, 0, 0, 0, 6'b000001, M_NOWR);
    // nxd_clr alone clears nxd while busy (in REQ).
    add_v(0, "t6d_start",      1, 1, 0, 0, 0, 0, 6'b100101, M_ALL);
    add_v(0, "t6d_clr_req",    1, 0, 0, 0, 0, 1, 6'b100100, M_ALL);
    add_v(0, "t6d_grant",      1, 0, 0, 1, 0, 0, 6'b001100, M_ALL);
    add_v(0, "t6d_ack",        1, 0, 0, 0, 1, 0, 6'b000110, M_NOWR);
    add_v(0, "t6d_idle",       1, 0, 0, 0, 0, 0, 6'b000000, M_NOWR);

    // Table B, u_dut3 (TIMEOUT=3): clken toggles 1/0 through a timeout.
    add_v(1, "t5_start_en",    1, 1, 0, 0, 0, 0, 6'b100100, M_ALL);
    add_v(1, "t5_hold_req",    0, 0, 0, 1, 0, 0, 6'b100100, M_ALL);
    add_v(1, "t5_grant_en",    1, 0, 0, 1, 0, 0, 6'b001100, M_ALL);
    add_v(1, "t5_hold_w1",     0, 0, 0, 0, 1, 0, 6'b001100, M_ALL);
    add_v(1, "t5_wait_en1",    1, 0, 0, 0, 0, 0, 6'b001100, M_ALL);
    add_v(1, "t5_hold_w2",     0, 0, 0, 0, 0, 0, 6'b001100, M_ALL);
    add_v(1, "t5_wait_en2",    1, 0, 0, 0, 0, 0, 6'b001100, M_ALL);
    add_v(1, "t5_hold_w3",     0, 0, 0, 0, 0, 0, 6'b001100, M_ALL);
    add_v(1, "t5_timeout_en",  1, 0, 0, 0, 0, 0, 6'b000111, M_NOWR);
    add_v(1, "t5_hold_done",   0, 0, 0, 0, 0, 0, 6'b000111, M_NOWR);
    add_v(1, "t5_idle_en",     1, 0, 0, 0, 0, 0, 6'b000001, M_NOWR);
    add_v(1, "t5_start_off",   0, 1, 1, 0, 0, 1, 6'b000001, M_NOWR);
    add_v(1, "t5_idle_en2",    1, 0, 0, 0, 0, 0, 6'b000001, M_NOWR);

    // Reset state.
    drive_idle();
    rst_n = 1'b0;
    #12;
    check("reset_out4", obs4, 6'b000000, M_ALL);
    check("reset_out3", obs3, 6'b000000, M_ALL);
    check_st("reset_state4", st4, 2'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset asserted mid-WAIT with clken=0 acts immediately.
    begin
      vec_t v;
      v.name = "t1_start"; v.en = 1; v.start = 1; v.wr = 1; v.grant = 0;
      v.ack = 0; v.clr = 0; v.exp = 6'b110100; v.mask = M_ALL;
      apply(v, 0);
      v.name = "t1_grant"; v.start = 0; v.wr = 0; v.grant = 1;
      v.exp = 6'b011100;
      apply(v, 0);
      check_st("t1_in_wait", st4, 2'd2);
      drive_idle();
      clken = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("t1_async_rst", obs4, 6'b000000, M_ALL);
      check_st("t1_async_state", st4, 2'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      v.name = "t1_after_rel"; v.grant = 0; v.exp = 6'b000000;
      apply(v, 0);
      check_st("t1_idle_state", st4, 2'd0);
    end

    foreach (vecs_a[i]) apply(vecs_a[i], 0);

    pulse_reset();
    foreach (vecs_b[i]) apply(vecs_b[i], 1);
    check_st("t5_final_state", st3, 2'd0);

    drive_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
